spi_reg_bridge: RTL and testbench

SPI mode-0 target that turns 16-bit serial frames into single accesses on the register-bank application interface (`wr_rdn`/`addr`/`wdata`/`we`/`rdata`/`ack`/`err`). It is the initiator on that interface and sits between the chip pads and the config/status register bank. All SPI pins are oversampled in the system clock domain, so no SPI-clocked logic exists.

---
 rtl/spi_reg_pkg.sv | 7 +
 rtl/spi_sync.sv | 19 +
 rtl/spi_reg_bridge.sv | 129 ++++++++++++
 tb/tb_spi_reg_bridge.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding and frame geometry for the SPI register bridge
package spi_reg_pkg;
  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, DATA, WR_REQ, DONE} spi_state_t;
  function automatic int frame_len(input int addr_w, input int reg_w);
    return 1 + addr_w + reg_w;
  endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-FF synchronizer with rise/fall detection for an asynchronous pin
module spi_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= {3{INIT}};
    else s <= {s[1:0], d};
  assign lvl = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: oversampled SPI mode-0 target issuing single register-bank accesses
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int REG_W  = 8,
  parameter int ADDR_W = 7,
  parameter int ACK_TO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic [REG_W-1:0]  rdata,
  input  logic              ack,
  input  logic              err,
  output logic              frame_err
);
  localparam int N  = frame_len(ADDR_W, REG_W);
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(ACK_TO + 1);
  spi_state_t state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] wcnt;
  logic [ADDR_W-1:0] cmd;
  logic [REG_W-1:0] sr, rx;
  logic first, fall_d;
  logic sclk_lvl, sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall, mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;
  logic [ADDR_W:0] cmd_next;
  logic [REG_W-1:0] rx_next;
  logic wait_done;
  spi_sync u_sclk (.clk(clk), .rst(rst), .d(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync #(.INIT(1'b1)) u_cs (.clk(clk), .rst(rst), .d(cs_n), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync u_mosi (.clk(clk), .rst(rst), .d(mosi), .lvl(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};
  assign cmd_next = {cmd, mosi_s};
  assign rx_next = {rx[REG_W-2:0], mosi_s};
  assign wait_done = wcnt == TW'(ACK_TO - 1);
  assign miso_oe = ena && state != IDLE;
  assign we = ena && state == WR_REQ;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      cmd <= '0;
      sr <= '0;
      rx <= '0;
      first <= 1'b0;
      fall_d <= 1'b0;
      miso <= 1'b0;
      wr_rdn <= 1'b0;
      addr <= '0;
      wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      fall_d <= cs_fall;
      miso <= state == DATA ? sr[REG_W-1] : 1'b0;
      if (!ena) state <= IDLE;
      else case (state)
        // fall_d catches a select that dropped on the very cycle IDLE was re-entered
        IDLE: if (cs_fall || fall_d) begin
          state <= CMD;
          cnt <= '0;
        end
        CMD: if (cs_rise) begin
          frame_err <= 1'b1;
          state <= IDLE;
        end else if (sclk_rise) begin
          cmd <= cmd_next[ADDR_W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ADDR_W)) begin
            wr_rdn <= cmd_next[ADDR_W];
            addr <= cmd_next[ADDR_W-1:0];
            first <= 1'b1;
            wcnt <= '0;
            sr <= '0;
            state <= cmd_next[ADDR_W] ? DATA : RD_REQ;
          end
        end
        RD_REQ: begin
          wcnt <= wcnt + 1'b1;
          if (sclk_fall) first <= 1'b0;
          if (ack || wait_done) begin
            sr <= (ack && !err) ? rdata : '1;
            frame_err <= !ack || err;
            state <= cs_lvl ? IDLE : DATA;
          end
        end
        // the first falling edge seen belongs to the last command bit and must not shift
        DATA: if (cs_rise) begin
          frame_err <= 1'b1;
          state <= IDLE;
        end else begin
          if (sclk_fall) begin
            first <= 1'b0;
            if (!first) sr <= {sr[REG_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            rx <= rx_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              wcnt <= '0;
              if (wr_rdn) wdata <= rx_next;
              state <= wr_rdn ? WR_REQ : DONE;
            end
          end
        end
        WR_REQ: begin
          wcnt <= wcnt + 1'b1;
          if (ack || wait_done) begin
            frame_err <= !ack || err;
            state <= cs_lvl ? IDLE : DONE;
          end
        end
        DONE: if (cs_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: randomized SPI frames checked against a frame-level model of the bridge
module tb_spi_reg_bridge;
  localparam int REG_W = 8, ADDR_W = 7, ACK_TO = 4;
  logic clk = 0, rst = 1, ena = 1, sclk = 0, cs_n = 1, mosi = 0, ack = 1, err = 0;
  logic miso, miso_oe, wr_rdn, we, frame_err;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0] wdata, rdata;
  logic [REG_W-1:0] mem [128];
  int total = 0, bad = 0;
  int we_cnt = 0, ferr_cnt = 0, oe_cnt = 0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic [REG_W-1:0] cap_wdata = '0;
  logic cap_wr = 0;
  spi_reg_bridge #(.REG_W(REG_W), .ADDR_W(ADDR_W), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata),
    .we(we), .rdata(rdata), .ack(ack), .err(err), .frame_err(frame_err)
  );
  assign rdata = mem[addr];
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (we) begin
      we_cnt++;
      cap_addr = addr;
      cap_wdata = wdata;
      cap_wr = wr_rdn;
    end
    if (frame_err) ferr_cnt++;
    if (miso_oe) oe_cnt++;
  end
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_xfer(input logic [15:0] f, input int nbits, input bit end_cs, output logic [7:0] rx);
    rx = '0;
    cs_n = 0;
    ticks(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      ticks(8);
      if (i >= 8) rx[15-i] = miso;
      sclk = 1;
      ticks(8);
      sclk = 0;
    end
    ticks(8);
    if (end_cs) begin
      cs_n = 1;
      ticks(8);
    end
  endtask
  task automatic test_reset();
    ticks(3);
    total++; if ({miso, miso_oe, we, wr_rdn, frame_err} !== 5'b0) begin bad++; $display("FAIL reset_bits got=%b exp=00000", {miso, miso_oe, we, wr_rdn, frame_err}); end
    total++; if (addr !== 7'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
    rst = 0;
    ticks(4);
  endtask
  task automatic test_write(input logic [6:0] a, input logic [7:0] d);
    int w0, f0, exp_we, exp_fe;
    logic [7:0] rx;
    w0 = we_cnt; f0 = ferr_cnt;
    exp_we = ack ? 1 : ACK_TO;
    exp_fe = (!ack || err) ? 1 : 0;
    spi_xfer({1'b1, a, d}, 16, 1, rx);
    total++; if (we_cnt - w0 !== exp_we) begin bad++; $display("FAIL write_we_cycles got=%0d exp=%0d", we_cnt - w0, exp_we); end
    total++; if (ferr_cnt - f0 !== exp_fe) begin bad++; $display("FAIL write_frame_err got=%0d exp=%0d", ferr_cnt - f0, exp_fe); end
    total++; if ({cap_wr, cap_addr, cap_wdata} !== {1'b1, a, d}) begin bad++; $display("FAIL write_access got=%h exp=%h", {cap_wr, cap_addr, cap_wdata}, {1'b1, a, d}); end
  endtask
  task automatic test_read(input logic [6:0] a);
    int w0, f0, exp_fe;
    logic [7:0] rx, exp;
    w0 = we_cnt; f0 = ferr_cnt;
    exp = (ack && !err) ? mem[a] : 8'hFF;
    exp_fe = (!ack || err) ? 1 : 0;
    spi_xfer({1'b0, a, 8'($urandom)}, 16, 1, rx);
    total++; if (rx !== exp) begin bad++; $display("FAIL read_miso addr=%h got=%h exp=%h", a, rx, exp); end
    total++; if (we_cnt != w0) begin bad++; $display("FAIL read_we got=%0d exp=0", we_cnt - w0); end
    total++; if (ferr_cnt - f0 !== exp_fe) begin bad++; $display("FAIL read_frame_err got=%0d exp=%0d", ferr_cnt - f0, exp_fe); end
  endtask
  task automatic test_abort();
    int w0, f0;
    logic [7:0] rx;
    w0 = we_cnt; f0 = ferr_cnt;
    spi_xfer({1'b1, 7'($urandom), 8'($urandom)}, 10, 1, rx);
    total++; if (we_cnt != w0) begin bad++; $display("FAIL abort_we got=%0d exp=0", we_cnt - w0); end
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL abort_frame_err got=%0d exp=1", ferr_cnt - f0); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL abort_idle_oe got=%b exp=0", miso_oe); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] rx;
    spi_xfer({1'b1, 7'h55, 8'hAA}, 12, 0, rx);
    rst = 1;
    #1;
    total++; if ({miso, miso_oe, we, wr_rdn, frame_err} !== 5'b0) begin bad++; $display("FAIL midrst_bits got=%b exp=00000", {miso, miso_oe, we, wr_rdn, frame_err}); end
    total++; if ({addr, wdata} !== 15'h0) begin bad++; $display("FAIL midrst_regs got=%h exp=0000", {addr, wdata}); end
    cs_n = 1;
    ticks(4);
    rst = 0;
    ticks(4);
    test_write(7'($urandom), 8'($urandom));
  endtask
  task automatic test_ena();
    int w0, f0, o0;
    logic [7:0] rx;
    ena = 0;
    w0 = we_cnt; f0 = ferr_cnt; o0 = oe_cnt;
    spi_xfer({1'b1, 7'h12, 8'h34}, 16, 1, rx);
    total++; if (we_cnt != w0) begin bad++; $display("FAIL ena_we got=%0d exp=0", we_cnt - w0); end
    total++; if (oe_cnt != o0) begin bad++; $display("FAIL ena_oe got=%0d exp=0", oe_cnt - o0); end
    total++; if (ferr_cnt != f0) begin bad++; $display("FAIL ena_frame_err got=%0d exp=0", ferr_cnt - f0); end
    ena = 1;
    ticks(4);
  endtask
  task automatic test_ack_fault();
    ack = 0;
    test_read(7'($urandom));
    test_write(7'($urandom), 8'($urandom));
    ack = 1; err = 1;
    test_read(7'($urandom));
    test_write(7'($urandom), 8'($urandom));
    err = 0;
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++)
      if ($urandom_range(0, 1) == 1) test_write(7'($urandom), 8'($urandom));
      else test_read(7'($urandom));
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h41] = 8'h3C;
    test_reset();
    test_write(7'h03, 8'hA5);
    test_read(7'h41);
    test_abort();
    test_ack_fault();
    test_reset_mid();
    test_ena();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
